// File: rtl/ik_fixed_pkg.sv
// Q15.20 fixed-point types and saturating arithmetic shared by the IK datapath, plus the DLS solver state enum.
package ik_fixed_pkg;

    localparam int FX_W    = 36;
    localparam int FX_FRAC = 20;
    localparam int N_JOINT = 6;
    localparam int PW      = 2 * FX_W;

    typedef logic signed [FX_W-1:0] fx_t;

    localparam fx_t FX_MAX = {1'b0, {(FX_W-1){1'b1}}};
    localparam fx_t FX_MIN = {1'b1, {(FX_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIVOT,
        S_FACTOR,
        S_ELIM,
        S_BACK,
        S_SCALE,
        S_DONE
    } dls_state_t;

    // Bits above the kept window must all equal its sign bit, else clamp.
    function automatic fx_t fx_mul(input fx_t a, input fx_t b);
        logic signed [PW-1:0] p;
        p = PW'(a) * PW'(b);
        if (p[PW-1:FX_W+FX_FRAC-1] != {(FX_W-FX_FRAC+1){p[FX_W+FX_FRAC-1]}})
            return p[PW-1] ? FX_MIN : FX_MAX;
        return p[FX_W+FX_FRAC-1:FX_FRAC];
    endfunction

    function automatic fx_t fx_add(input fx_t a, input fx_t b);
        logic signed [FX_W:0] s;
        s = (FX_W+1)'(a) + (FX_W+1)'(b);
        if (s[FX_W] != s[FX_W-1])
            return s[FX_W] ? FX_MIN : FX_MAX;
        return s[FX_W-1:0];
    endfunction

    function automatic fx_t fx_sub(input fx_t a, input fx_t b);
        logic signed [FX_W:0] s;
        s = (FX_W+1)'(a) - (FX_W+1)'(b);
        if (s[FX_W] != s[FX_W-1])
            return s[FX_W] ? FX_MIN : FX_MAX;
        return s[FX_W-1:0];
    endfunction

endpackage

// File: rtl/fx_recip.sv
// Fixed-point reciprocal (1<<40)/d by restoring division on |d|, sign restored at the end, saturated.
// Latency: done_o exactly DIV_CYCLES cycles after start_i; no backpressure, a new start_i restarts it.
module fx_recip
    import ik_fixed_pkg::*;
#(
    parameter int DIV_CYCLES = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  fx_t  d_i,
    output logic done_o,
    output fx_t  r_o
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic                  busy_q;
    logic                  neg_q;
    logic [FX_W-1:0]       dmag_q;
    logic [FX_W-1:0]       rem_q;
    logic [DIV_CYCLES-2:0] quo_q;
    logic [CW-1:0]         cnt_q;

    logic [FX_W-1:0]       d_mag;
    logic [FX_W:0]         rem_sh;
    logic [FX_W:0]         diff;
    logic                  ge;
    logic [FX_W-1:0]       rem_d;
    logic [DIV_CYCLES-1:0] quo_d;
    fx_t                   mag;

    assign d_mag  = d_i[FX_W-1] ? FX_W'(-d_i) : d_i;
    assign rem_sh = {rem_q, 1'b0};
    assign diff   = rem_sh - {1'b0, dmag_q};
    assign ge     = ~diff[FX_W];
    assign rem_d  = ge ? diff[FX_W-1:0] : rem_sh[FX_W-1:0];
    assign quo_d  = {quo_q, ge};
    assign done_o = busy_q && (cnt_q == CW'(1));

    // The leading dividend bit is pre-loaded as remainder 1; |d| <= 1 overflows into the clamp below.
    always_comb begin
        mag = {1'b0, quo_d[FX_W-2:0]};
        if (|quo_d[DIV_CYCLES-1:FX_W-1])
            mag = FX_MAX;
        r_o = neg_q ? -mag : mag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            neg_q  <= 1'b0;
            dmag_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            neg_q  <= d_i[FX_W-1];
            dmag_q <= d_mag;
            rem_q  <= FX_W'(1);
            quo_q  <= '0;
            cnt_q  <= CW'(DIV_CYCLES);
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d[DIV_CYCLES-2:0];
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1))
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/dls_solver.sv
// Solves (J*J^T + bias) x = e by Gaussian elimination without pivoting, one shared multiply per cycle.
// Latency: done 6*(DIV_CYCLES+1)+107 cycles after start; start is ignored unless idle, no backpressure.
module dls_solver
    import ik_fixed_pkg::*;
#(
    parameter int N          = N_JOINT,
    parameter int DIV_CYCLES = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [N-1:0][N-1:0][FX_W-1:0] jjt_bias,
    input  logic [N-1:0][FX_W-1:0]        err,
    output logic [N-1:0][FX_W-1:0]        x,
    output logic                         busy,
    output logic                         done,
    output logic                         singular
);

    localparam int  IW      = $clog2(N + 1);
    localparam int  CW      = $clog2(DIV_CYCLES + 1);
    localparam fx_t PIV_MIN = fx_t'(16);

    typedef logic [IW-1:0] idx_t;

    dls_state_t    state_q, state_d;
    idx_t          k_q, i_q, j_q;
    logic [CW-1:0] pcnt_q;
    fx_t           a_q [N][N+1];
    fx_t           r_q [N];
    fx_t           x_q [N];
    fx_t           f_q, s_q;
    logic          singular_q;

    fx_t  piv, recip, mul_a, mul_b, prod, scale_src, back_acc;
    logic piv_bad, piv_last, div_start, div_done;

    assign piv       = a_q[k_q][k_q];
    assign piv_bad   = (piv < PIV_MIN) && (piv > -PIV_MIN);
    assign div_start = (state_q == S_PIVOT) && (pcnt_q == '0);
    assign piv_last  = div_done && (pcnt_q == CW'(DIV_CYCLES));
    assign scale_src = (i_q == idx_t'(N-1)) ? a_q[i_q][N] : s_q;
    assign back_acc  = (j_q == i_q + 1'b1) ? a_q[i_q][N] : s_q;
    assign singular  = singular_q;

    fx_recip #(.DIV_CYCLES(DIV_CYCLES)) u_recip (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .d_i     (piv),
        .done_o  (div_done),
        .r_o     (recip)
    );

    // The single multiplier; every arithmetic state feeds it one operand pair.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_FACTOR: begin mul_a = a_q[i_q][k_q]; mul_b = r_q[k_q];    end
            S_ELIM:   begin mul_a = f_q;           mul_b = a_q[k_q][j_q]; end
            S_BACK:   begin mul_a = a_q[i_q][j_q]; mul_b = x_q[j_q];    end
            S_SCALE:  begin mul_a = scale_src;     mul_b = r_q[i_q];    end
            default: ;
        endcase
        prod = fx_mul(mul_a, mul_b);
        for (int i = 0; i < N; i++)
            x[i] = x_q[i];
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        case (state_q)
            S_IDLE:   if (start) state_d = S_PIVOT;
            S_PIVOT:  if (piv_last) begin
                          if (piv_bad)                      state_d = S_DONE;
                          else if (k_q == idx_t'(N-1))      state_d = S_SCALE;
                          else                              state_d = S_FACTOR;
                      end
            S_FACTOR: state_d = S_ELIM;
            S_ELIM:   if (j_q == idx_t'(N))
                          state_d = (i_q == idx_t'(N-1)) ? S_PIVOT : S_FACTOR;
            S_BACK:   if (j_q == idx_t'(N-1)) state_d = S_SCALE;
            S_SCALE:  state_d = (i_q == '0) ? S_DONE : S_BACK;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            pcnt_q     <= '0;
            f_q        <= '0;
            s_q        <= '0;
            singular_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_q[i] <= '0;
                x_q[i] <= '0;
                for (int j = 0; j <= N; j++)
                    a_q[i][j] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++)
                            a_q[i][j] <= jjt_bias[i][j];
                        a_q[i][N] <= err[i];
                        x_q[i]    <= '0;
                    end
                    k_q        <= '0;
                    pcnt_q     <= '0;
                    singular_q <= 1'b0;
                end
                S_PIVOT: begin
                    pcnt_q <= pcnt_q + 1'b1;
                    if (piv_last) begin
                        pcnt_q <= '0;
                        if (piv_bad) begin
                            singular_q <= 1'b1;
                            for (int i = 0; i < N; i++)
                                x_q[i] <= '0;
                        end else begin
                            r_q[k_q] <= recip;
                            i_q      <= (k_q == idx_t'(N-1)) ? idx_t'(N-1) : k_q + 1'b1;
                        end
                    end
                end
                S_FACTOR: begin
                    f_q <= prod;
                    j_q <= k_q + 1'b1;
                end
                S_ELIM: begin
                    a_q[i_q][j_q] <= fx_sub(a_q[i_q][j_q], prod);
                    if (j_q == idx_t'(N)) begin
                        if (i_q == idx_t'(N-1)) k_q <= k_q + 1'b1;
                        else                    i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                S_BACK: begin
                    s_q <= fx_sub(back_acc, prod);
                    j_q <= j_q + 1'b1;
                end
                S_SCALE: begin
                    x_q[i_q] <= prod;
                    if (i_q != '0) begin
                        i_q <= i_q - 1'b1;
                        j_q <= i_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
